mem_port_arbiter: RTL

Shares one single-ported unified memory between the instruction-fetch stage and the data-access stage (LW, SW, LB, SV). Only one request is in flight at a time. Requests are granted by priority, with a starvation guard for fetch. The block holds the memory req/ack handshake, aligns and extends byte data, and drops fetch responses killed by a taken branch, jump or return. It produces per-requester stall signals that feed the pipeline stall network alongside hazard-detect stalls.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/byte_lane_align.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM state encoding and access size codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StFetchWait = 2'b01,
    StDataWait  = 2'b10,
    StFetchDrop = 2'b11
  } arb_state_e;

  // Same encoding as NumOfByte from the main control decoder; 2'b11 behaves as a word.
  localparam logic [1:0] SZ_WORD   = 2'b00;
  localparam logic [1:0] SZ_BYTE_U = 2'b01;
  localparam logic [1:0] SZ_BYTE_S = 2'b10;

  function automatic logic is_byte(input logic [1:0] size);
    return (size == SZ_BYTE_U) || (size == SZ_BYTE_S);
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte lane handling for the data port: load extract/extend, store lane replication and
// byte-enable generation. Purely combinational.
module byte_lane_align
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [1:0]        rd_size_i,
  input  logic              rd_addr0_i,
  input  logic [DATA_W-1:0] rd_word_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [1:0]        wr_size_i,
  input  logic              wr_addr0_i,
  input  logic [DATA_W-1:0] wr_word_i,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [1:0]        wr_be_o
);

  logic [7:0] rd_byte;

  always_comb begin
    rd_byte = rd_addr0_i ? rd_word_i[15:8] : rd_word_i[7:0];
    case (rd_size_i)
      SZ_BYTE_U: rd_data_o = {{(DATA_W-8){1'b0}}, rd_byte};
      SZ_BYTE_S: rd_data_o = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
      default:   rd_data_o = rd_word_i;
    endcase
  end

  always_comb begin
    wr_data_o = wr_word_i;
    wr_be_o   = 2'b11;
    if (is_byte(wr_size_i)) begin
      // Store byte goes out on both lanes; the byte enable picks the one memory keeps.
      wr_data_o       = '0;
      wr_data_o[15:0] = {2{wr_word_i[7:0]}};
      wr_be_o         = wr_addr0_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access, one access in
// flight, data-first priority with a fetch starvation guard and kill-driven fetch drop.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              kill,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned       StarveW   = $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [1:0]          lat_size_q, lat_size_d;
  logic                lat_addr0_q, lat_addr0_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                d_valid_q, d_valid_d;

  logic [DATA_W-1:0]   rd_ext;
  logic [DATA_W-1:0]   wr_lane;
  logic [1:0]          wr_be;
  logic                done, can_grant, fetch_ok, data_ok, grant_d, grant_f;

  byte_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .rd_size_i (lat_size_q),
    .rd_addr0_i(lat_addr0_q),
    .rd_word_i (mem_rdata),
    .rd_data_o (rd_ext),
    .wr_size_i (d_size),
    .wr_addr0_i(d_addr[0]),
    .wr_word_i (d_wdata),
    .wr_data_o (wr_lane),
    .wr_be_o   (wr_be)
  );

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    lat_size_d  = lat_size_q;
    lat_addr0_d = lat_addr0_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_valid_d   = 1'b0;

    done      = (state_q != StIdle) && mem_ack;
    can_grant = (state_q == StIdle) || done;
    // A fetch seen together with kill is stale; the fetch stage re-requests the new target.
    fetch_ok  = if_req && !kill;
    data_ok   = d_rd || d_wr;
    grant_d   = can_grant && data_ok && ((starve_q < StarveMax) || !fetch_ok);
    grant_f   = can_grant && !grant_d && fetch_ok;

    if (done) begin
      state_d   = StIdle;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
      if (state_q == StFetchWait && !kill) begin
        if_valid_d = 1'b1;
        if_rdata_d = mem_rdata;
      end
      if (state_q == StDataWait) begin
        d_valid_d = 1'b1;
        if (!mem_we_q) d_rdata_d = rd_ext;
      end
    end else if (state_q == StFetchWait && kill) begin
      state_d = StFetchDrop;
    end

    if (grant_d) begin
      state_d     = StDataWait;
      mem_req_d   = 1'b1;
      mem_we_d    = d_wr;
      mem_addr_d  = is_byte(d_size) ? {d_addr[ADDR_W-1:1], 1'b0} : d_addr;
      mem_wdata_d = wr_lane;
      mem_be_d    = wr_be;
      lat_size_d  = d_size;
      lat_addr0_d = d_addr[0];
    end else if (grant_f) begin
      state_d     = StFetchWait;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_be_d    = 2'b11;
    end

    if (grant_f || !if_req) begin
      starve_d = '0;
    end else if (grant_d && (starve_q < StarveMax)) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      lat_size_q  <= SZ_WORD;
      lat_addr0_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 2'b00;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      lat_size_q  <= lat_size_d;
      lat_addr0_q <= lat_addr0_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      d_rdata_q   <= d_rdata_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_stall   = (d_rd | d_wr) & ~d_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule
